decoder_rr_sequencer: RTL
=========================

Name: decoder_rr_sequencer

Overview:
- Shares one decoder instance between NUM_REQ requesters.
- Round-robin arbitrates requests and drives the winner's 7-bit code onto the decoder input for DEC_LAT cycles.
- Captures the decoder output and returns it to the winner over a valid/ready response channel.
- Sits between the requester-side logic and decoder_proj in the decoder project.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CODE_W, 7, code width driven to the decoder.
- OUT_W, 16, decoder output width.
- DEC_LAT, 2, cycles the code is held before dec_out is sampled (>=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_code  in  NUM_REQ*CODE_W  codes, requester i at bits [i*CODE_W +: CODE_W].
- req_ready  out  NUM_REQ  one-hot accept; combinational, asserted only in IDLE.
- dec_in  out  CODE_W  registered code to the decoder.
- dec_en  out  1  high while dec_in carries a live code.
- dec_out  in  OUT_W  decoder result.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_data  out  OUT_W  captured result.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last winner.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - State=IDLE, rr_ptr=0.
  - dec_in, dec_en, rsp_valid, rsp_data, busy and grant_id all go to 0.
  - req_ready=0 while reset is asserted.
  - An in-flight transaction is dropped with no response.
- Arbitration:
  - In IDLE the winner g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 in that same cycle; the handshake completes that cycle.
  - No valid requests: req_ready=0 and the block stays in IDLE.
- States:
  - IDLE: on accept, latch req_code[g] into dec_in, set dec_en=1, grant_id=g, cnt=DEC_LAT-1, go to DRIVE.
  - DRIVE: dec_in and dec_en are held constant. If cnt=0, rsp_data<=dec_out and go to RESP; otherwise cnt<=cnt-1.
  - RESP: dec_en=0 and dec_in=0. rsp_valid[grant_id]=1 and rsp_data is held. When rsp_ready[grant_id]=1, clear rsp_valid, set rr_ptr<=(grant_id+1) mod NUM_REQ, go to IDLE.
- Timing:
  - Accept in cycle 0.
  - dec_en is high for cycles 1..DEC_LAT.
  - dec_out is sampled at the end of cycle DEC_LAT.
  - rsp_valid rises in cycle DEC_LAT+1.
  - Next accept no earlier than cycle DEC_LAT+2, so peak throughput is 1 per DEC_LAT+2 cycles.
- Boundaries:
  - req_valid changes outside IDLE are ignored; a dropped request is not accepted later unless it is reasserted.
  - rsp_ready from non-granted requesters is ignored.
  - A requester that holds rsp_ready=0 stalls the block indefinitely in RESP; no timeout.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A lone requester is re-granted every DEC_LAT+2 cycles.
  - grant_id holds its last value in IDLE.
  - If a new request and the completing rsp_ready arrive in the same cycle, the new request is evaluated in the following IDLE cycle.

Test Plan:
- Reset then single request:
  - Stimulus: reset_n low then released; req_valid=4'b0001, req_code[0]=7'b1011010, dec_out=16'h00A5.
  - Required: req_ready=4'b0001 in cycle 0; dec_in=7'h5A and dec_en=1 in cycles 1-2; rsp_valid=4'b0001 and rsp_data=16'h00A5 in cycle 3; with rsp_ready[0]=1, busy=0 in cycle 4.
- Round robin:
  - Stimulus: req_valid=4'b1111 held, rsp_ready=4'b1111.
  - Required: grant order 0,1,2,3,0; grants spaced exactly 4 cycles apart.
- Wrap and skip:
  - Stimulus: rr_ptr=3 after serving 2; req_valid=4'b0101.
  - Required: requester 0 granted next, then 2.
- Backpressure:
  - Stimulus: rsp_ready[1]=0 for 10 cycles while other requests are pending.
  - Required: rsp_valid[1] and rsp_data stable throughout; req_ready stays 0; requester 1 completes when rsp_ready[1]=1.
- Reset mid-operation:
  - Stimulus: reset_n=0 asserted in DRIVE cycle 1.
  - Required: all outputs 0 immediately (asynchronous); after release, the first grant goes to requester 0 and no stale response appears.
- Ignored signals:
  - Stimulus: req_valid[2] toggled during DRIVE; rsp_ready[3]=1 while requester 0 is granted.
  - Required: no state change, no extra req_ready, rsp_valid unaffected.

Source files
------------

// File: rtl/decoder_rr_sequencer.sv
// decoder_rr_sequencer: shares one decoder between NUM_REQ requesters.
// A round-robin winner's code is held on dec_in for DEC_LAT cycles. The decoder
// result is then captured and returned to the winner over a valid/ready channel.
module decoder_rr_sequencer #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CODE_W  = 7,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned DEC_LAT = 2,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CODE_W-1:0] req_code,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [CODE_W-1:0]         dec_in,
    output logic                      dec_en,
    input  logic [OUT_W-1:0]          dec_out,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [OUT_W-1:0]          rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned CNT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResp
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   win;
    logic              any_req;
    logic [CODE_W-1:0] codes [NUM_REQ];

    // Unpack the flat code bus so the winner's code can be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_codes
        assign codes[i] = req_code[i*CODE_W +: CODE_W];
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin : p_arb
        int unsigned idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req_valid[ID_W'(idx)]) begin
                win     = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Accept is combinational and only offered in IDLE outside reset.
    always_comb begin
        req_ready = '0;
        if (reset_n && (state == StIdle) && any_req) begin
            req_ready[win] = 1'b1;
        end
    end

    assign busy = (state != StIdle);

    // Sequencer FSM with registered decoder and response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            cnt       <= '0;
            dec_in    <= '0;
            dec_en    <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        dec_in   <= codes[win];
                        dec_en   <= 1'b1;
                        grant_id <= win;
                        cnt      <= CNT_W'(DEC_LAT - 1);
                        state    <= StDrive;
                    end
                end
                StDrive: begin
                    if (cnt == '0) begin
                        rsp_data            <= dec_out;
                        dec_en              <= 1'b0;
                        dec_in              <= '0;
                        rsp_valid           <= '0;
                        rsp_valid[grant_id] <= 1'b1;
                        state               <= StResp;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StResp: begin
                    // Only the granted requester can complete the response.
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
